// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path.
package mips_pkg;

   // Opcodes (instr[31:26]) that the controller recognises
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // ALUOp values consumed by ALUControl
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALU B-input select
   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   // PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11
   } state_t;

   // Datapath control vector produced for each state
   typedef struct packed {
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsrc;
      logic       pcen;
   } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// State-to-control decoder: pure combinational lookup of datapath controls.
module mips_ctrl_decode
   import mips_pkg::*;
(
   input  state_t state,
   input  logic   mem_ready,
   input  logic   zero,
   output ctrl_t  ctrl
);

   // Map the current state (plus ready/zero qualifiers) onto the control vector
   always_comb begin
      // NOTE: clear every field first so no path through the case leaves a latch.
      ctrl = '0;
      case (state)
         FETCH: begin
            ctrl.alusrcb = SRCB_FOUR;
            ctrl.aluop   = ALUOP_ADD;
            ctrl.pcsrc   = PCSRC_ALU;
            ctrl.irwrite = mem_ready;
            ctrl.pcen    = mem_ready;
         end
         DECODE: ctrl.alusrcb = SRCB_IMMSH;
         MEMADR: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_IMM;
         end
         MEMRD: ctrl.iord = 1'b1;
         MEMWB: begin
            ctrl.memtoreg = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         MEMWR: begin
            ctrl.iord     = 1'b1;
            ctrl.memwrite = 1'b1;
         end
         EXECUTE: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_B;
            ctrl.aluop   = ALUOP_FUNCT;
         end
         ALUWB: begin
            ctrl.regdst   = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         BRANCH: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_B;
            ctrl.aluop   = ALUOP_SUB;
            ctrl.pcsrc   = PCSRC_ALUOUT;
            ctrl.pcen    = zero;
         end
         ADDIEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_IMM;
         end
         ADDIWB: ctrl.regwrite = 1'b1;
         JUMP: begin
            ctrl.pcsrc = PCSRC_JUMP;
            ctrl.pcen  = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: state register,
// opcode-driven sequencing and retired-instruction counter.
module mips_multicycle_ctrl
   import mips_pkg::*;
#(
   parameter bit USE_MEM_READY = 1'b1,
   parameter int CNT_W         = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             IorD,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             RegDst,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       PCSrc,
   output logic             PCEn,
   output logic             illegal_op,
   output logic [3:0]       state_o,
   output logic [CNT_W-1:0] retired
);

   state_t state_q, state_d;
   ctrl_t  ctrl;
   logic   mem_rdy;
   logic   illegal_d;
   logic   retire;

   assign mem_rdy = USE_MEM_READY ? mem_ready : 1'b1;

   mips_ctrl_decode u_decode (
      .state     (state_q),
      .mem_ready (mem_rdy),
      .zero      (zero),
      .ctrl      (ctrl)
   );

   // State register; reset returns to FETCH from any point in an instruction
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   // Next-state selection and illegal-opcode detection
   always_comb begin
      state_d   = FETCH;
      illegal_d = 1'b0;
      case (state_q)
         FETCH:   state_d = mem_rdy ? DECODE : FETCH;
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXECUTE;
               OP_BEQ:       state_d = BRANCH;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JUMP;
               default: begin
                  state_d   = FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            if (opcode == OP_LW)      state_d = MEMRD;
            else if (opcode == OP_SW) state_d = MEMWR;
            else                      state_d = FETCH;
         end
         MEMRD:   state_d = mem_rdy ? MEMWB : MEMRD;
         MEMWR:   state_d = mem_rdy ? FETCH : MEMWR;
         EXECUTE: state_d = ALUWB;
         ADDIEX:  state_d = ADDIWB;
         default: state_d = FETCH;   // write-back, branch, jump and undefined codes
      endcase
   end

   // An instruction retires on its final cycle
   always_comb begin
      case (state_q)
         MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: retire = 1'b1;
         MEMWR:                              retire = mem_rdy;
         default:                            retire = 1'b0;
      endcase
   end

   // Retired-instruction counter, wraps naturally at 2^CNT_W
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       retired <= '0;
      else if (retire) retired <= retired + CNT_W'(1);
   end

   // Write enables are held off for as long as reset is asserted
   assign IorD       = ctrl.iord;
   assign MemWrite   = ctrl.memwrite & ~reset;
   assign IRWrite    = ctrl.irwrite  & ~reset;
   assign RegDst     = ctrl.regdst;
   assign MemtoReg   = ctrl.memtoreg;
   assign RegWrite   = ctrl.regwrite & ~reset;
   assign ALUSrcA    = ctrl.alusrca;
   assign ALUSrcB    = ctrl.alusrcb;
   assign ALUOp      = ctrl.aluop;
   assign PCSrc      = ctrl.pcsrc;
   assign PCEn       = ctrl.pcen & ~reset;
   assign illegal_op = illegal_d & ~reset;
   assign state_o    = state_q;

endmodule
